// File: rtl/wb_stage_if.sv
// Writeback stage bus: memory-stage handshake, data-memory return and register-file write side.
interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_reg_write;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        write_en;
    logic        load_err;
    logic [31:0] retire_count;

    modport master (
        output in_valid, in_rd, in_result, in_reg_write, in_is_load, in_funct3,
        output mem_rvalid, mem_rdata,
        input  in_ready, write_reg, write_data, write_en, load_err, retire_count
    );

    modport slave (
        input  in_valid, in_rd, in_result, in_reg_write, in_is_load, in_funct3,
        input  mem_rvalid, mem_rdata,
        output in_ready, write_reg, write_data, write_en, load_err, retire_count
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results next cycle, waits for memory on loads, extracts/extends load data.
// Stalls upstream (in_ready=0) only while waiting for load data or in reset.
module wb_stage (
    input  logic      clk,
    input  logic      rst,
    wb_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t      state, state_nx;
    logic [4:0]  wr_reg, wr_reg_nx;
    logic [31:0] wr_data, wr_data_nx;
    logic        wr_en, wr_en_nx;
    logic        err, err_nx;
    logic [31:0] retire_cnt, retire_cnt_nx;
    logic [4:0]  p_rd, p_rd_nx;
    logic [2:0]  p_f3, p_f3_nx;
    logic        p_rw, p_rw_nx;
    logic [1:0]  p_addr, p_addr_nx;
    logic        xfer, bad_load;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'd0, b};
            3'b101:  extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    assign bus.in_ready     = (state != WAIT_MEM) && !rst;
    assign xfer             = bus.in_valid && bus.in_ready;
    assign bus.write_reg    = wr_reg;
    assign bus.write_data   = wr_data;
    assign bus.write_en     = wr_en;
    assign bus.load_err     = err;
    assign bus.retire_count = retire_cnt;

    // Illegal funct3 or misaligned access commits immediately as an error, no memory wait.
    always_comb begin
        bad_load = 1'b0;
        case (bus.in_funct3)
            3'b000, 3'b100: bad_load = 1'b0;
            3'b001, 3'b101: bad_load = bus.in_result[0];
            3'b010:         bad_load = (bus.in_result[1:0] != 2'b00);
            default:        bad_load = 1'b1;
        endcase
    end

    always_comb begin
        state_nx   = state;
        wr_reg_nx  = wr_reg;
        wr_data_nx = wr_data;
        wr_en_nx   = 1'b0;
        err_nx     = 1'b0;
        p_rd_nx    = p_rd;
        p_f3_nx    = p_f3;
        p_rw_nx    = p_rw;
        p_addr_nx  = p_addr;
        case (state)
            IDLE, COMMIT: begin
                state_nx = IDLE;
                if (xfer) begin
                    if (!bus.in_is_load) begin
                        state_nx   = COMMIT;
                        wr_en_nx   = bus.in_reg_write && (bus.in_rd != 5'd0);
                        wr_reg_nx  = bus.in_rd;
                        wr_data_nx = bus.in_result;
                    end else if (bad_load) begin
                        state_nx = COMMIT;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx  = WAIT_MEM;
                        p_rd_nx   = bus.in_rd;
                        p_f3_nx   = bus.in_funct3;
                        p_rw_nx   = bus.in_reg_write;
                        p_addr_nx = bus.in_result[1:0];
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_nx   = COMMIT;
                    wr_en_nx   = p_rw && (p_rd != 5'd0);
                    wr_reg_nx  = p_rd;
                    wr_data_nx = extract(p_f3, p_addr, bus.mem_rdata);
                end
            end
            default: state_nx = IDLE;
        endcase
        // Counter is bumped on entry so it already reflects the retiring instruction in its COMMIT cycle.
        retire_cnt_nx = (state_nx == COMMIT) ? retire_cnt + 32'd1 : retire_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_reg     <= 5'd0;
            wr_data    <= 32'd0;
            wr_en      <= 1'b0;
            err        <= 1'b0;
            retire_cnt <= 32'd0;
            p_rd       <= 5'd0;
            p_f3       <= 3'd0;
            p_rw       <= 1'b0;
            p_addr     <= 2'd0;
        end else begin
            state      <= state_nx;
            wr_reg     <= wr_reg_nx;
            wr_data    <= wr_data_nx;
            wr_en      <= wr_en_nx;
            err        <= err_nx;
            retire_cnt <= retire_cnt_nx;
            p_rd       <= p_rd_nx;
            p_f3       <= p_f3_nx;
            p_rw       <= p_rw_nx;
            p_addr     <= p_addr_nx;
        end
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream (memory stage) holds a valid instruction.
REQ-005 in_ready  output  1  stage accepts an instruction this cycle; transfer = in_valid & in_ready.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_result  input  32  ALU result; for loads, byte address (bits [1:0] select lane).
REQ-008 in_reg_write  input  1  instruction writes rd.
REQ-009 in_is_load  input  1  instruction is a load; data comes from mem_rdata.
REQ-010 in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 mem_rdata  input  32  aligned 32-bit word from data memory.
REQ-013 write_reg  output  5  register file write index.
REQ-014 write_data  output  32  register file write data.
REQ-015 write_en  output  1  register file write strobe, one cycle per write.
REQ-016 load_err  output  1  one-cycle pulse: misaligned or illegal load.
REQ-017 retire_count  output  32  retired-instruction counter.

Function
REQ-018 States SHALL be IDLE, WAIT_MEM, COMMIT; in_ready = 1 in IDLE and COMMIT, 0 in WAIT_MEM and while rst=1.
REQ-019 Non-load transfer at edge N SHALL enter COMMIT, with write_en=in_reg_write&(in_rd!=0), write_reg=in_rd, write_data=in_result registered at edge N (visible cycle N+1).
REQ-020 Load transfer SHALL latch rd, funct3, reg_write, addr[1:0] and enter WAIT_MEM; mem_rvalid in the accept cycle SHALL be ignored.
REQ-021 In WAIT_MEM, first edge with mem_rvalid=1 SHALL register extracted data and enter COMMIT; write visible next cycle; no timeout.
REQ-022 Extraction: LB/LBU byte at addr[1:0]*8, LH/LHU halfword at addr[1]*16; LB/LH sign-extend, LBU/LHU zero-extend; LW whole word.
REQ-023 Misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0) or funct3 in {011,110,111} SHALL go directly to COMMIT without waiting, write_en=0, load_err=1 for that COMMIT cycle.
REQ-024 rd=0 SHALL never assert write_en; instruction still retires.
REQ-025 From COMMIT: transfer this cycle behaves as from IDLE (back-to-back, 1 instr/cycle for non-loads); else return to IDLE.
REQ-026 write_en and load_err SHALL be 1 only in COMMIT cycles; write_reg/write_data SHALL hold last value otherwise.
REQ-027 retire_count SHALL increment by 1 per COMMIT cycle (including errored and rd=0), wrapping 0xFFFFFFFF->0.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, write_en=0, load_err=0, write_reg=0, write_data=0, retire_count=0.
REQ-029 Reset in WAIT_MEM or COMMIT SHALL discard the pending instruction with no write; later mem_rvalid in IDLE ignored.

Verification
REQ-030 ALU op rd=1, result 0x00001511, reg_write=1 -> next cycle write_en=1, write_reg=1, write_data=0x00001511, retire_count=1.
REQ-031 Three back-to-back ALU ops rd=1,2,3 (0x1511,0x123,0x312) -> write_en high 3 consecutive cycles, in_ready never low, retire_count=3.
REQ-032 LB addr 0x...3, rvalid after 2 cycles, mem_rdata=0x80FF7F01 -> write_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x...2 -> 0x000080FF.
REQ-033 LW addr 0x...2 -> no memory wait, write_en=0, load_err=1 one cycle, retire_count increments.
REQ-034 ALU op rd=0 reg_write=1 -> write_en stays 0, retire_count increments.
REQ-035 Load accepted, rst pulsed in WAIT_MEM, then mem_rvalid=1 -> no write_en, retire_count=0, in_ready=1.
